// File: rtl/sort_pkg.sv
// Purpose : shared types and constants for the sort sequencer slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Build option: SORT_ASCEND_EN selects ascending order (smallest word first);
//               left undefined, the block sorts descending (largest first).
package sort_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int SORT_N_DEF = 5;
   localparam int SORT_W_DEF = 8;

   // Width of an index into an n-entry array; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

`ifdef SORT_ASCEND_EN
   localparam bit SORT_ASCEND = 1'b1;
`else
   localparam bit SORT_ASCEND = 1'b0;
`endif

endpackage

// File: rtl/sort_cmp_swap.sv
// Purpose : one compare-swap cell; decides whether an adjacent pair is out of order.
// Latency : purely combinational.
// Backpressure: none.
// Ports: a, b        - word at p and word at p+1
//        swap_needed - pair is out of order for the configured direction
//        first,second- the pair in the required order (first belongs at p)
module sort_cmp_swap
   import sort_pkg::*;
#(
   parameter int W = SORT_W_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         swap_needed,
   output logic [W-1:0] first,
   output logic [W-1:0] second
);

   // Strict comparison: equal words never swap, which keeps the sort stable
   // and avoids spurious extra passes on ties.
   always_comb begin
      swap_needed = SORT_ASCEND ? (a > b) : (a < b);
      first       = swap_needed ? b : a;
      second      = swap_needed ? a : b;
   end

endmodule

// File: rtl/sort_sequencer.sv
// Purpose : loads N words, bubble-sorts them in place (one compare-swap per cycle), streams them out.
// Latency : sort takes (passes x (N-1)) cycles after the Nth input beat; N-1 min, N*(N-1) max.
// Backpressure: in_ready only in LOAD, out_valid only in DRAIN; out_data held while out_ready=0.
// Ports: clk, rst (async, active-high), flush (sync abort to LOAD)
//        in_valid/in_ready/in_data    - producer stream
//        out_valid/out_ready/out_data/out_last - consumer stream, r[0] first
//        busy - high in SORT or DRAIN
// Build option: SORT_ASCEND_EN (see sort_pkg) flips the sort direction only.
module sort_sequencer
   import sort_pkg::*;
#(
   parameter int N = SORT_N_DEF,
   parameter int W = SORT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int            IW       = idx_width(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
   localparam logic [IW-1:0] PEND_IDX = IW'(N - 2);
   localparam logic [IW-1:0] ONE      = IW'(1);

   state_t        state;
   logic [IW-1:0] ld_idx;
   logic [IW-1:0] p;
   logic [IW-1:0] p_nxt;
   logic [IW-1:0] out_idx;
   logic          swp;
   logic [W-1:0]  r [N];

   logic          swap_needed;
   logic [W-1:0]  cs_first;
   logic [W-1:0]  cs_second;

   assign p_nxt = p + ONE;

   // Single compare-swap cell, steered by the pass pointer.
   sort_cmp_swap #(.W(W)) u_cmp (
      .a           (r[p]),
      .b           (r[p_nxt]),
      .swap_needed (swap_needed),
      .first       (cs_first),
      .second      (cs_second)
   );

   // Handshake outputs depend only on registered state, never on the peers.
   assign in_ready  = (state == LOAD);
   assign out_valid = (state == DRAIN);
   assign out_last  = (state == DRAIN) && (out_idx == LAST_IDX);
   assign busy      = (state != LOAD);
   assign out_data  = r[out_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= LOAD;
         ld_idx  <= '0;
         p       <= '0;
         swp     <= 1'b0;
         out_idx <= '0;
         for (int i = 0; i < N; i++) begin
            r[i] <= '0;
         end
      end else if (flush) begin
         // Storage is left as-is; the next job overwrites every word.
         state   <= LOAD;
         ld_idx  <= '0;
         p       <= '0;
         swp     <= 1'b0;
         out_idx <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  r[ld_idx] <= in_data;
                  if (ld_idx == LAST_IDX) begin
                     state  <= SORT;
                     ld_idx <= '0;
                     p      <= '0;
                     swp    <= 1'b0;
                  end else begin
                     ld_idx <= ld_idx + ONE;
                  end
               end
            end

            SORT: begin
               if (swap_needed) begin
                  r[p]     <= cs_first;
                  r[p_nxt] <= cs_second;
               end
               if (p == PEND_IDX) begin
                  // End of pass: a swap anywhere in it (including this
                  // cycle's) means the array may still be unsorted.
                  if (swp || swap_needed) begin
                     p   <= '0;
                     swp <= 1'b0;
                  end else begin
                     state   <= DRAIN;
                     out_idx <= '0;
                  end
               end else begin
                  p   <= p_nxt;
                  swp <= swp || swap_needed;
               end
            end

            DRAIN: begin
               if (out_ready) begin
                  if (out_idx == LAST_IDX) begin
                     state   <= LOAD;
                     ld_idx  <= '0;
                     out_idx <= '0;
                  end else begin
                     out_idx <= out_idx + ONE;
                  end
               end
            end

            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sort_sequencer.sv
module tb_sort_sequencer;
   import sort_pkg::*;

   localparam int N = 5;
   localparam int W = 8;

   typedef logic [W-1:0] job_t [N];
   typedef struct {
      job_t din;
      job_t dout;
      int   cycles;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         busy;

   int checks = 0;
   int failures = 0;

   sort_sequencer #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // True when x placed before y violates the configured order.
   function automatic bit wrong_order(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SORT_ASCEND_EN
      return x > y;
`else
      return x < y;
`endif
   endfunction

   function automatic job_t model_sort(input job_t a);
      job_t b;
      b = a;
      for (int i = 1; i < N; i++) begin
         logic [W-1:0] key;
         int j;
         key = b[i];
         j = i;
         while (j > 0 && wrong_order(b[j-1], key)) begin
            b[j] = b[j-1];
            j--;
         end
         b[j] = key;
      end
      return b;
   endfunction

   // Bubble passes needed = largest number of earlier words any word must
   // overtake, plus one clean pass; each pass is N-1 cycles.
   function automatic int model_cycles(input job_t a);
      int m;
      m = 0;
      for (int i = 0; i < N; i++) begin
         int c;
         c = 0;
         for (int j = 0; j < i; j++) if (wrong_order(a[j], a[i])) c++;
         if (c > m) m = c;
      end
      return (m + 1) * (N - 1);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic load_job(input string name, input job_t a);
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = a[i];
         check({name, "_in_ready"}, in_ready, 1);
         tick();
      end
      // Keep offering junk during SORT/DRAIN; it must be ignored.
      in_valid = 1'b1;
      in_data  = 8'hFF;
   endtask

   task automatic wait_sort(input string name, input int exp_cycles);
      int cnt;
      cnt = 0;
      out_ready = 1'b1;
      check({name, "_busy_sort"}, busy, 1);
      while (!out_valid && cnt < 400) begin
         if (in_ready) begin
            check({name, "_in_ready_in_sort"}, in_ready, 0);
         end
         tick();
         cnt++;
      end
      check({name, "_sort_cycles"}, cnt, exp_cycles);
   endtask

   task automatic drain_job(input string name, input job_t exp, input bit rnd);
      int k, cyc;
      logic [W-1:0] held;
      bit stalled;
      k = 0; cyc = 0; stalled = 0; held = '0;
      while (k < N && cyc < 400) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         check({name, "_out_valid"}, out_valid, 1);
         if (!out_valid) break;
         if (stalled) check({name, "_held"}, out_data, held);
         if (out_ready) begin
            check({name, $sformatf("_data%0d", k)}, out_data, exp[k]);
            check({name, $sformatf("_last%0d", k)}, out_last, (k == N - 1) ? 1 : 0);
            k++;
            stalled = 0;
         end else begin
            held = out_data;
            stalled = 1;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({name, "_beats"}, k, N);
      check({name, "_in_ready_after"}, in_ready, 1);
      check({name, "_out_valid_after"}, out_valid, 0);
      check({name, "_busy_after"}, busy, 0);
   endtask

   // ---------------- test sequence ----------------
   vec_t tbl [4];

   initial begin
`ifdef SORT_ASCEND_EN
      tbl[0] = '{din: '{8'd8, 8'd10, 8'd13, 8'd45, 8'd1}, dout: '{8'd1, 8'd8, 8'd10, 8'd13, 8'd45}, cycles: 20};
      tbl[1] = '{din: '{8'd45, 8'd13, 8'd10, 8'd8, 8'd1}, dout: '{8'd1, 8'd8, 8'd10, 8'd13, 8'd45}, cycles: 20};
      tbl[2] = '{din: '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, dout: '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, cycles: 4};
      tbl[3] = '{din: '{8'd7, 8'd7, 8'd3, 8'd7, 8'd3}, dout: '{8'd3, 8'd3, 8'd7, 8'd7, 8'd7}, cycles: 16};
`else
      tbl[0] = '{din: '{8'd8, 8'd10, 8'd13, 8'd45, 8'd1}, dout: '{8'd45, 8'd13, 8'd10, 8'd8, 8'd1}, cycles: 16};
      tbl[1] = '{din: '{8'd45, 8'd13, 8'd10, 8'd8, 8'd1}, dout: '{8'd45, 8'd13, 8'd10, 8'd8, 8'd1}, cycles: 4};
      tbl[2] = '{din: '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, dout: '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, cycles: 20};
      tbl[3] = '{din: '{8'd7, 8'd7, 8'd3, 8'd7, 8'd3}, dout: '{8'd7, 8'd7, 8'd7, 8'd3, 8'd3}, cycles: 8};
`endif

      // Reset state.
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", in_ready, 1);

      // Directed table.
      for (int v = 0; v < 4; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         load_job(nm, tbl[v].din);
         wait_sort(nm, tbl[v].cycles);
         drain_job(nm, tbl[v].dout, (v == 3));
      end

      // flush in the middle of SORT.
      load_job("flush", tbl[0].din);
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_in_ready", in_ready, 1);
      check("flush_out_valid", out_valid, 0);
      check("flush_busy", busy, 0);
      load_job("post_flush", tbl[2].din);
      wait_sort("post_flush", tbl[2].cycles);
      drain_job("post_flush", tbl[2].dout, 1'b0);

      // rst in the middle of DRAIN, after two output beats.
      load_job("rstdrain", tbl[0].din);
      wait_sort("rstdrain", tbl[0].cycles);
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("rstdrain_d0", out_data, tbl[0].dout[0]);
      tick();
      check("rstdrain_d1", out_data, tbl[0].dout[1]);
      tick();
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("rstdrain_in_ready", in_ready, 1);
      check("rstdrain_out_valid", out_valid, 0);
      check("rstdrain_out_data", out_data, 0);
      check("rstdrain_out_last", out_last, 0);
      check("rstdrain_busy", busy, 0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rstdrain_no_partial", out_valid, 0);
      out_ready = 1'b0;
      load_job("post_rst", tbl[3].din);
      wait_sort("post_rst", tbl[3].cycles);
      drain_job("post_rst", tbl[3].dout, 1'b1);

      // Randomized jobs against the reference model.
      for (int t = 0; t < 30; t++) begin
         job_t a;
         string nm;
         nm = $sformatf("rnd%0d", t);
         for (int i = 0; i < N; i++) begin
            a[i] = (t % 2 == 0) ? W'($urandom_range(0, 7)) : W'($urandom_range(0, 255));
         end
         load_job(nm, a);
         wait_sort(nm, model_cycles(a));
         drain_job(nm, model_sort(a), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sort_sequencer.md
# sort_sequencer

Controller that sequences a small in-place compare-swap sort array of N words. It accepts N words over a valid/ready input stream and sorts them with pointer-driven bubble passes, one adjacent compare-swap per cycle. It then streams the sorted words out over a valid/ready output stream. It sits between a producer and a consumer that both use the team's standard stream handshake.

## Interface
- N, 5, number of words per sort job; legal range 2..16
- W, 8, word width in bits
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous abort; returns to LOAD
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts a word (LOAD state only)
- in_data  in  W  input word
- out_valid  out  1  sorted word available (DRAIN state only)
- out_ready  in  1  consumer accepts a word
- out_data  out  W  sorted word, r[out_idx]
- out_last  out  1  marks the final word of a job
- busy  out  1  high in SORT or DRAIN

## Operation
- Storage is r[0..N-1], W bits each. Reset sets all words to 0.
- States:
  - LOAD: in_ready=1. Each in_valid&in_ready beat writes r[ld_idx], then ld_idx++. The beat with ld_idx=N-1 moves the block to SORT with p=0 and swp=0.
  - SORT: each cycle compares r[p] and r[p+1].
    - If they are out of order, swap them at the clock edge and set swp.
    - At p=N-2, if swp is set (this cycle's swap included), start a new pass: p=0, swp=0. Otherwise go to DRAIN with out_idx=0.
    - Otherwise p++.
  - DRAIN: out_valid=1, out_data=r[out_idx], out_last=(out_idx==N-1). Each out_valid&out_ready beat does out_idx++. The beat with out_last returns the block to LOAD with ld_idx=0.
- Order: r[0] is emitted first. The default is descending, so "out of order" means r[p] < r[p+1].
- Comparison is strict unsigned, so equal words never swap (the sort is stable).
- flush has priority over all state activity and has lower priority than rst.
  - Next state is LOAD; ld_idx, p, swp and out_idx clear.
  - r contents are retained but invalid.
- in_valid while not in LOAD is ignored. out_ready while not in DRAIN is ignored.

## Timing
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- in_ready, out_valid, out_last and busy are decoded from registered state, with no combinational path from in_valid or out_ready.
- First SORT cycle is the cycle after the Nth input beat.
- Each pass takes exactly N-1 cycles.
  - Minimum sort time, already ordered: N-1 cycles.
  - Maximum sort time, reverse ordered: N*(N-1) cycles.
- out_valid asserts the cycle after the final clean pass.
- Throughput: one input beat and one output beat per cycle when the peer is always ready.
- out_data is stable while out_valid=1 and out_ready=0.
- Asserting rst mid-SORT or mid-DRAIN forces the reset values immediately. No partial output follows reset release.

## Configuration
- SORT_ASCEND_EN
  - Defined: ascending order. "Out of order" means r[p] > r[p+1], and the smallest word is emitted first.
  - Undefined: descending order, as above.
- The interface is identical in both builds.

## Structure
- Package sort_pkg holds:
  - state enum {LOAD, SORT, DRAIN}
  - default N and W localparams
  - the index width function, $clog2(N)
  - the SORT_ASCEND direction constant, derived from the macro
- Sub-module sort_cmp_swap: purely combinational. Takes two W-bit words and outputs swap_needed plus the ordered pair. It is instantiated once, at pointer p.

## Test plan
- Load 08,10,13,45,01 (descending build), out_ready=1 → exactly 16 SORT cycles, then output 45,13,10,08,01 with out_last on 01.
- Load 45,13,10,08,01, already sorted → 4 SORT cycles, output unchanged. Then load 01,02,03,04,05 → 20 SORT cycles, output 05..01.
- Load 07,07,03,07,03 → output 07,07,07,03,03. No swap is counted between equal words; sort takes 8 cycles.
- out_ready toggled 1,0,0,1 pseudo-randomly during DRAIN → no word lost or duplicated, and out_data is held during stalls. in_valid asserted during SORT and DRAIN is not accepted.
- flush during SORT, and separately rst during DRAIN (after 2 output beats) → block returns to LOAD with in_ready=1 and out_valid=0. A fresh 5-word job then sorts correctly.
- SORT_ASCEND_EN build, load 08,10,13,45,01 → output 01,08,10,13,45.
